// File: rtl/uart_cmd_parser_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_cmd_parser_if                                          |
// | Description : Byte-stream and frame-consumer signal bundle for the UART   |
// |               command parser. The master modport is the parser side; the  |
// |               slave modport is the UART receiver / frame consumer side.   |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface uart_cmd_parser_if;

  // Byte stream from the UART receiver
  logic [7:0] rx_data;
  logic       rx_done;

  // Held-frame handshake and payload read port
  logic       frame_vld;
  logic       frame_ack;
  logic [7:0] cmd;
  logic [4:0] frame_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  // Status pulses
  logic       frame_err;
  logic [1:0] err_code;
  logic       ovr;

  modport master (
    input  rx_data,
    input  rx_done,
    input  frame_ack,
    input  rd_addr,
    output frame_vld,
    output cmd,
    output frame_len,
    output rd_data,
    output frame_err,
    output err_code,
    output ovr
  );

  modport slave (
    output rx_data,
    output rx_done,
    output frame_ack,
    output rd_addr,
    input  frame_vld,
    input  cmd,
    input  frame_len,
    input  rd_data,
    input  frame_err,
    input  err_code,
    input  ovr
  );

endinterface
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_cmd_parser                                             |
// | Description : Parses HEADER/cmd/len/payload[/checksum] frames from a UART |
// |               byte stream, holds a complete frame for a consumer until    |
// |               frame_ack, and flags length, timeout and checksum errors.   |
// |               Optional macro UART_CMD_CHKSUM_EN adds the trailing 8-bit   |
// |               modulo-sum checksum byte (CHK state).                       |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module uart_cmd_parser #(
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50_000
) (
  input wire                sys_clk,
  input wire                sys_rst_n,
  uart_cmd_parser_if.master cmd_bus
);

  // Timeout counter only needs to reach TIMEOUT_CYC-1
  localparam int                 c_TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
  localparam logic [7:0]         c_MAX_LEN  = 8'(MAX_LEN);

  localparam logic [1:0] c_ERR_BADLEN  = 2'd1;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'd2;
`ifdef UART_CMD_CHKSUM_EN
  localparam logic [1:0] c_ERR_CHKSUM  = 2'd3;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

  // Where the FSM goes once the last payload byte (or a zero length) is seen
`ifdef UART_CMD_CHKSUM_EN
  localparam state_t c_ST_AFTER_PAYLOAD = ST_CHK;
`else
  localparam state_t c_ST_AFTER_PAYLOAD = ST_HOLD;
`endif

  state_t         r_state;
  state_t         w_state_nxt;

  logic [7:0]     r_cmd;
  logic [4:0]     r_len;
  logic [3:0]     r_idx;
  logic [7:0]     r_buf [0:15];
  logic [c_TMO_W-1:0] r_tmo_cnt;

  logic           r_frame_vld;
  logic           r_frame_err;
  logic [1:0]     r_err_code;
  logic           r_ovr;

  logic           w_active;
  logic           w_tmo;
  logic           w_last_byte;
  logic           w_cmd_we;
  logic           w_len_we;
  logic           w_buf_we;
  logic           w_err;
  logic [1:0]     w_err_code;
  logic           w_ovr;

`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]     r_sum;
`endif

  // Frame-collecting states are the only ones subject to the inter-byte timeout
  assign w_active    = (r_state == ST_CMD) || (r_state == ST_LEN) ||
                       (r_state == ST_DATA) || (r_state == ST_CHK);
  // A byte arriving on the expiry cycle wins over the timeout
  assign w_tmo       = w_active && !cmd_bus.rx_done && (r_tmo_cnt == c_TMO_LAST);
  assign w_last_byte = ({1'b0, r_idx} == (r_len - 5'd1));

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_we    = 1'b0;
    w_len_we    = 1'b0;
    w_buf_we    = 1'b0;
    w_err       = 1'b0;
    w_err_code  = 2'd0;
    w_ovr       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Non-header bytes are dropped without comment
        if (cmd_bus.rx_done && (cmd_bus.rx_data == HEADER)) begin
          w_state_nxt = ST_CMD;
        end
      end

      ST_CMD: begin
        if (cmd_bus.rx_done) begin
          w_cmd_we    = 1'b1;
          w_state_nxt = ST_LEN;
        end
      end

      ST_LEN: begin
        if (cmd_bus.rx_done) begin
          if (cmd_bus.rx_data > c_MAX_LEN) begin
            w_err       = 1'b1;
            w_err_code  = c_ERR_BADLEN;
            w_state_nxt = ST_IDLE;
          end else begin
            w_len_we    = 1'b1;
            w_state_nxt = (cmd_bus.rx_data == 8'd0) ? c_ST_AFTER_PAYLOAD : ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (cmd_bus.rx_done) begin
          w_buf_we = 1'b1;
          if (w_last_byte) begin
            w_state_nxt = c_ST_AFTER_PAYLOAD;
          end
        end
      end

      ST_CHK: begin
`ifdef UART_CMD_CHKSUM_EN
        if (cmd_bus.rx_done) begin
          if (cmd_bus.rx_data == r_sum) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_err       = 1'b1;
            w_err_code  = c_ERR_CHKSUM;
            w_state_nxt = ST_IDLE;
          end
        end
`else
        // Unreachable without the checksum option
        w_state_nxt = ST_IDLE;
`endif
      end

      ST_HOLD: begin
        // The held frame is never overwritten; extra bytes are reported
        if (cmd_bus.rx_done) begin
          w_ovr = 1'b1;
        end
        if (r_frame_vld && cmd_bus.frame_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Timeout only fires in states where no byte arrived this cycle
    if (w_tmo) begin
      w_err       = 1'b1;
      w_err_code  = c_ERR_TIMEOUT;
      w_state_nxt = ST_IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame header fields and payload write index
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cmd <= 8'd0;
      r_len <= 5'd0;
      r_idx <= 4'd0;
    end else begin
      if (w_cmd_we) begin
        r_cmd <= cmd_bus.rx_data;
      end
      if (w_len_we) begin
        r_len <= cmd_bus.rx_data[4:0];
        r_idx <= 4'd0;
      end else if (w_buf_we) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  // Payload buffer; contents are don't-care until a frame is held
  always_ff @(posedge sys_clk) begin
    if (w_buf_we) begin
      r_buf[r_idx] <= cmd_bus.rx_data;
    end
  end

  // Inter-byte timeout counter, idle outside the frame-collecting states
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (!w_active || cmd_bus.rx_done || w_tmo) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
    end
  end

  // Registered status outputs: frame_vld tracks HOLD, the rest are pulses
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_frame_vld <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 2'd0;
      r_ovr       <= 1'b0;
    end else begin
      r_frame_vld <= (w_state_nxt == ST_HOLD);
      r_frame_err <= w_err;
      r_err_code  <= w_err_code;
      r_ovr       <= w_ovr;
    end
  end

`ifdef UART_CMD_CHKSUM_EN
  // Running modulo-256 sum of cmd, len and payload bytes
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sum <= 8'd0;
    end else if (w_cmd_we) begin
      r_sum <= cmd_bus.rx_data;
    end else if (w_len_we || w_buf_we) begin
      r_sum <= r_sum + cmd_bus.rx_data;
    end
  end
`endif

  assign cmd_bus.frame_vld = r_frame_vld;
  assign cmd_bus.cmd       = r_cmd;
  assign cmd_bus.frame_len = r_len;
  assign cmd_bus.rd_data   = r_buf[cmd_bus.rd_addr];
  assign cmd_bus.frame_err = r_frame_err;
  assign cmd_bus.err_code  = r_err_code;
  assign cmd_bus.ovr       = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_cmd_parser                                          |
// | Description : Directed self-checking bench for uart_cmd_parser. Honours   |
// |               UART_CMD_CHKSUM_EN by appending checksum bytes.             |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_uart_cmd_parser;

  localparam int TMO = 200;

  logic sys_clk;
  logic sys_rst_n;
  int   n_cmp;
  int   n_err;
  logic [7:0] sum;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .HEADER      (8'hAA),
    .MAX_LEN     (16),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cmd_bus   (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic send_chk(input logic [7:0] c);
`ifdef UART_CMD_CHKSUM_EN
    send_byte(c);
`else
    if (c == 8'h00) begin end
`endif
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    bus.rd_addr = a;
    #1;
    check(tag, bus.rd_data, exp);
  endtask

  task automatic ack();
    bus.frame_ack = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.frame_ack = 1'b0;
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    bus.rx_data   = 8'h00;
    bus.rx_done   = 1'b0;
    bus.frame_ack = 1'b0;
    bus.rd_addr   = 4'd0;
    sys_rst_n     = 1'b1;

    // Reset state
    #3 sys_rst_n = 1'b0;
    #1;
    check("rst_vld",  bus.frame_vld, 0);
    check("rst_err",  bus.frame_err, 0);
    check("rst_code", bus.err_code,  0);
    check("rst_ovr",  bus.ovr,       0);
    check("rst_cmd",  bus.cmd,       0);
    check("rst_len",  bus.frame_len, 0);
    idle(2);
    sys_rst_n = 1'b1;
    idle(1);

    // Garbage in IDLE is silently ignored
    send_byte(8'h55);
    check("idle_garbage_err", bus.frame_err, 0);
    check("idle_garbage_vld", bus.frame_vld, 0);

    // Basic 3-byte frame
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02);
    check("f1_vld_early", bus.frame_vld, 0);
    send_byte(8'h03);
    send_chk(8'h19);
    check("f1_vld", bus.frame_vld, 1);
    check("f1_cmd", bus.cmd, 8'h10);
    check("f1_len", bus.frame_len, 3);
    read_chk("f1_rd0", 4'd0, 8'h01);
    read_chk("f1_rd1", 4'd1, 8'h02);
    read_chk("f1_rd2", 4'd2, 8'h03);

    // Extra bytes while held: ovr pulses, frame untouched
    send_byte(8'h55);
    check("ovr_1", bus.ovr, 1);
    send_byte(8'h66);
    check("ovr_2", bus.ovr, 1);
    idle(1);
    check("ovr_end", bus.ovr, 0);
    check("ovr_vld", bus.frame_vld, 1);
    check("ovr_cmd", bus.cmd, 8'h10);
    check("ovr_len", bus.frame_len, 3);
    read_chk("ovr_rd0", 4'd0, 8'h01);
    read_chk("ovr_rd1", 4'd1, 8'h02);
    read_chk("ovr_rd2", 4'd2, 8'h03);
    ack();
    check("f1_ack_vld", bus.frame_vld, 0);

    // Length above MAX_LEN
    send_byte(8'hAA); send_byte(8'h20); send_byte(8'h11);
    check("badlen_err",  bus.frame_err, 1);
    check("badlen_code", bus.err_code,  1);
    check("badlen_vld",  bus.frame_vld, 0);
    idle(1);
    check("badlen_pulse", bus.frame_err, 0);

    // Zero-length frame right after an error
    send_byte(8'hAA); send_byte(8'h21); send_byte(8'h00);
    send_chk(8'h21);
    check("z_vld", bus.frame_vld, 1);
    check("z_cmd", bus.cmd, 8'h21);
    check("z_len", bus.frame_len, 0);

    // frame_ack and rx_done together: byte dropped, frame released
    bus.frame_ack = 1'b1;
    send_byte(8'hAA);
    bus.frame_ack = 1'b0;
    check("ackrx_ovr", bus.ovr, 1);
    check("ackrx_vld", bus.frame_vld, 0);
    send_byte(8'hAA); send_byte(8'h40); send_byte(8'h01); send_byte(8'h7E);
    send_chk(8'hBF);
    check("f4_vld", bus.frame_vld, 1);
    check("f4_cmd", bus.cmd, 8'h40);
    read_chk("f4_rd0", 4'd0, 8'h7E);
    ack();

    // Maximum-length frame
    send_byte(8'hAA); send_byte(8'h70); send_byte(8'h10);
    sum = 8'h80;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i * 3 + 1));
      sum = sum + 8'(i * 3 + 1);
    end
    send_chk(sum);
    check("max_vld", bus.frame_vld, 1);
    check("max_len", bus.frame_len, 16);
    read_chk("max_rd0",  4'd0,  8'h01);
    read_chk("max_rd15", 4'd15, 8'h2E);
    ack();

    // Timeout: single pulse at count TMO-1
    send_byte(8'hAA); send_byte(8'h30);
    idle(TMO - 1);
    check("tmo_early", bus.frame_err, 0);
    idle(1);
    check("tmo_err",  bus.frame_err, 1);
    check("tmo_code", bus.err_code,  2);
    idle(1);
    check("tmo_pulse", bus.frame_err, 0);

    // Byte on the expiry cycle wins; counter restarts from it
    send_byte(8'hAA); send_byte(8'h30);
    idle(TMO - 1);
    send_byte(8'h05);
    check("race_err", bus.frame_err, 0);
    idle(TMO - 1);
    check("race_tmo_early", bus.frame_err, 0);
    idle(1);
    check("race_tmo_err",  bus.frame_err, 1);
    check("race_tmo_code", bus.err_code,  2);

    // Reset during DATA clears everything immediately
    send_byte(8'hAA); send_byte(8'h50); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02);
    sys_rst_n = 1'b0;
    #1;
    check("mrst_cmd", bus.cmd,       0);
    check("mrst_len", bus.frame_len, 0);
    check("mrst_vld", bus.frame_vld, 0);
    check("mrst_err", bus.frame_err, 0);
    check("mrst_ovr", bus.ovr,       0);
    idle(1);
    sys_rst_n = 1'b1;
    idle(1);
    check("mrst_noerr", bus.frame_err, 0);
    send_byte(8'hAA); send_byte(8'h60); send_byte(8'h02);
    send_byte(8'h0A); send_byte(8'h0B);
    send_chk(8'h77);
    check("post_vld", bus.frame_vld, 1);
    check("post_cmd", bus.cmd, 8'h60);
    check("post_len", bus.frame_len, 2);
    read_chk("post_rd0", 4'd0, 8'h0A);
    read_chk("post_rd1", 4'd1, 8'h0B);
    ack();

`ifdef UART_CMD_CHKSUM_EN
    // Checksum mismatch then match
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h01); send_byte(8'h05);
    send_byte(8'h00);
    check("chk_bad_err",  bus.frame_err, 1);
    check("chk_bad_code", bus.err_code,  3);
    check("chk_bad_vld",  bus.frame_vld, 0);
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h01); send_byte(8'h05);
    send_byte(8'h16);
    check("chk_ok_vld", bus.frame_vld, 1);
    check("chk_ok_err", bus.frame_err, 0);
    read_chk("chk_ok_rd0", 4'd0, 8'h05);
    ack();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter: HEADER, default 8'hAA, frame start byte.
REQ-002 Parameter: MAX_LEN, default 16, maximum payload bytes (1..16).
REQ-003 Parameter: TIMEOUT_CYC, default 50_000, inter-byte timeout in sys_clk cycles (1 ms at 50 MHz).
REQ-004 sys_clk  input  1  system clock, 50 MHz; the only clock.
REQ-005 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-006 rx_data  input  8  received byte from UART receiver; valid when rx_done=1.
REQ-007 rx_done  input  1  one-cycle pulse per received byte.
REQ-008 frame_vld  output  1  complete frame held for consumer.
REQ-009 frame_ack  input  1  consumer release; sampled only while frame_vld=1.
REQ-010 cmd  output  8  command byte of held frame.
REQ-011 frame_len  output  5  payload length of held frame (0..MAX_LEN).
REQ-012 rd_addr  input  4  payload buffer read index.
REQ-013 rd_data  output  8  payload byte at rd_addr, combinational read.
REQ-014 frame_err  output  1  one-cycle error pulse.
REQ-015 err_code  output  2  error cause, valid with frame_err: 1=BADLEN, 2=TIMEOUT, 3=CHKSUM.
REQ-016 ovr  output  1  one-cycle pulse when a byte is dropped in HOLD.

Function
REQ-017 Frame format SHALL be: HEADER, cmd, len, len payload bytes, [checksum].
REQ-018 FSM states SHALL be IDLE, CMD, LEN, DATA, CHK, HOLD; all transitions occur only on rx_done, timeout, or frame_ack.
REQ-019 IDLE: rx_done with rx_data==HEADER -> CMD; any other byte SHALL be discarded silently, no error.
REQ-020 CMD: rx_done -> latch cmd, -> LEN.
REQ-021 LEN: rx_done with rx_data>MAX_LEN -> frame_err, err_code=1, -> IDLE; rx_data==0 -> CHK (or HOLD if checksum disabled); else -> DATA.
REQ-022 DATA: each rx_done writes buffer[idx], idx increments from 0; after byte idx==len-1 -> CHK (or HOLD if checksum disabled).
REQ-023 Entering HOLD SHALL assert frame_vld on the next cycle; cmd, frame_len and buffer SHALL stay stable while frame_vld=1.
REQ-024 HOLD: frame_ack=1 -> frame_vld deasserts next cycle, -> IDLE; rx_done in HOLD SHALL drop the byte and pulse ovr.
REQ-025 Timeout counter SHALL clear on every rx_done and in IDLE/HOLD; when it reaches TIMEOUT_CYC-1 in CMD/LEN/DATA/CHK -> frame_err, err_code=2, -> IDLE.
REQ-026 rx_done in the same cycle as timeout expiry: byte SHALL win, counter clears, no error.
REQ-027 frame_ack and rx_done in the same HOLD cycle: byte dropped with ovr, FSM -> IDLE.
REQ-028 A byte after an error SHALL be treated as IDLE input (a HEADER starts a new frame at once).

Reset
REQ-029 On sys_rst_n=0, immediately: state=IDLE, frame_vld=0, frame_err=0, err_code=0, ovr=0, cmd=0, frame_len=0, counters=0; buffer contents need not be cleared.
REQ-030 Reset mid-frame SHALL abandon the frame with no frame_err pulse.

Configuration
REQ-031 Macro UART_CMD_CHKSUM_EN: when defined, CHK state is present; checksum = 8-bit modulo sum of cmd, len and payload; match -> HOLD, mismatch -> frame_err, err_code=3, -> IDLE.
REQ-032 When UART_CMD_CHKSUM_EN is undefined, no checksum byte is expected, CHK is never entered, and err_code=3 never occurs.

Verification
REQ-033 Bytes AA 10 03 01 02 03 [chk 19] -> frame_vld=1, cmd=8'h10, frame_len=3, rd_addr 0..2 give 01,02,03; frame_ack -> frame_vld=0 next cycle.
REQ-034 Bytes AA 20 11 -> frame_err pulse, err_code=1, no frame_vld; following AA 21 00 [21] -> frame_vld, frame_len=0.
REQ-035 Bytes AA 30, then no byte for 50_000 cycles -> single frame_err, err_code=2 at count 49_999; next byte at exactly expiry -> no error.
REQ-036 With UART_CMD_CHKSUM_EN: AA 10 01 05 [chk 00] -> frame_err, err_code=3; correct chk 16 -> frame_vld=1.
REQ-037 Frame held, extra bytes 55 66 sent before frame_ack -> two ovr pulses, cmd/len/buffer unchanged.
REQ-038 sys_rst_n pulsed low during DATA -> all outputs 0 immediately, next AA starts clean frame.
